// File: rtl/video_pkg.sv
// Shared definitions for the text-mode video compositor: RGB565 layout,
// cursor mode encodings and default colours.
package video_pkg;
  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;
  localparam int RGB_W = R_W + G_W + B_W;

  typedef enum logic [1:0] {
    CUR_OFF    = 2'b00,
    CUR_STEADY = 2'b01,
    CUR_BLINK  = 2'b10,
    CUR_ALT    = 2'b11
  } cur_mode_e;

  localparam logic [RGB_W-1:0] DEF_FG = 16'h0300;
  localparam logic [RGB_W-1:0] DEF_BG = 16'h0000;
endpackage

// File: rtl/delayline.sv
// Single-bit shift register delay of DEPTH clocks with async active-high reset.
module delayline #(
  parameter int DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  generate
    if (DEPTH == 0) begin : g_pass
      assign o_q = i_d;
    end else begin : g_sr
      logic [DEPTH-1:0] sr;
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) sr <= '0;
        else       sr <= (sr << 1) | DEPTH'(i_d);
      end
      assign o_q = sr[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/video_compositor.sv
// Merges the glyph pixel stream with a block cursor and bell-driven reverse
// video, producing registered RGB565 LCD colour.
module video_compositor
  import video_pkg::*;
#(
  parameter int               COLS         = 64,
  parameter int               ROWS         = 32,
  parameter int               CHAR_H       = 16,
  parameter int               DLY          = 2,
  parameter int               BLINK_FRAMES = 30,
  parameter int               BEL_FRAMES   = 8,
  parameter logic [RGB_W-1:0] FG_RGB       = DEF_FG,
  parameter logic [RGB_W-1:0] BG_RGB       = DEF_BG
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_vsync,
  input  logic                      i_pxon,
  input  logic [$clog2(COLS)-1:0]   i_cell_x,
  input  logic [$clog2(ROWS)-1:0]   i_cell_y,
  input  logic [$clog2(CHAR_H)-1:0] i_char_y,
  input  logic [$clog2(COLS)-1:0]   i_cur_x,
  input  logic [$clog2(ROWS)-1:0]   i_cur_y,
  input  logic [1:0]                i_cur_mode,
  input  logic [$clog2(CHAR_H)-1:0] i_cur_h,
  input  logic                      i_bel,
  output logic [R_W-1:0]            o_LCD_R,
  output logic [G_W-1:0]            o_LCD_G,
  output logic [B_W-1:0]            o_LCD_B,
  output logic                      o_cur_vis,
  output logic                      o_rev
);
  localparam int XW   = $clog2(COLS);
  localparam int YW   = $clog2(ROWS);
  localparam int CYW  = $clog2(CHAR_H);
  localparam int BLW  = $clog2(BLINK_FRAMES + 1);
  localparam int BEW  = $clog2(BEL_FRAMES + 1);

  logic            vs_q;
  logic            frame_ev;
  logic            frame_valid;
  logic [XW-1:0]   cur_x;
  logic [YW-1:0]   cur_y;
  cur_mode_e       cur_mode;
  logic [CYW-1:0]  cur_h;
  logic [BLW-1:0]  blink_cnt;
  logic [BEW-1:0]  bel_cnt;
  logic            bel_pend;
  logic            pos_chg;
  logic            hit;
  logic            hit_d;
  logic            pxon;

  assign frame_ev = vs_q & ~i_vsync;
  assign pos_chg  = (i_cur_x != cur_x) || (i_cur_y != cur_y);

  // NOTE: every register below uses non-blocking assignment so all state
  // updates see the same pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vs_q        <= 1'b1;
      frame_valid <= 1'b0;
      cur_x       <= '0;
      cur_y       <= '0;
      cur_mode    <= CUR_OFF;
      cur_h       <= '0;
      blink_cnt   <= '0;
      o_cur_vis   <= 1'b1;
      bel_cnt     <= '0;
      bel_pend    <= 1'b0;
    end else begin
      vs_q <= i_vsync;
      if (frame_ev) begin
        frame_valid <= 1'b1;
        cur_x       <= i_cur_x;
        cur_y       <= i_cur_y;
        cur_mode    <= cur_mode_e'(i_cur_mode);
        cur_h       <= i_cur_h;
        // A moved cursor restarts the blink phase visible, overriding the wrap.
        if (pos_chg) begin
          blink_cnt <= '0;
          o_cur_vis <= 1'b1;
        end else if (blink_cnt == BLW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          o_cur_vis <= ~o_cur_vis;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
        if (bel_pend || i_bel) begin
          bel_cnt  <= BEW'(BEL_FRAMES);
          bel_pend <= 1'b0;
        end else if (bel_cnt != '0) begin
          bel_cnt <= bel_cnt - 1'b1;
        end
      end else if (i_bel) begin
        bel_pend <= 1'b1;
      end
    end
  end

  assign o_rev = (bel_cnt != '0);

  // NOTE: hit is a pure combinational function given a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    hit = 1'b0;
    if (cur_mode != CUR_OFF && i_cell_x == cur_x && i_cell_y == cur_y &&
        ({1'b0, i_char_y} + {1'b0, cur_h}) >= (CYW + 1)'(CHAR_H - 1) &&
        (cur_mode != CUR_BLINK || o_cur_vis))
      hit = 1'b1;
  end

  delayline #(.DEPTH(DLY)) u_hit_dly (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (hit),
    .o_q   (hit_d)
  );

  assign pxon = i_pxon ^ hit_d ^ o_rev;

  // Colour stays background until the first frame has latched cursor state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      {o_LCD_R, o_LCD_G, o_LCD_B} <= '0;
    end else if (!frame_valid) begin
      {o_LCD_R, o_LCD_G, o_LCD_B} <= BG_RGB;
    end else begin
      {o_LCD_R, o_LCD_G, o_LCD_B} <= pxon ? FG_RGB : BG_RGB;
    end
  end
endmodule

// File: tb/tb_video_compositor.sv
// Directed self-checking bench for video_compositor with short blink/bell
// periods so several phases fit in a few simulated frames.
module tb_video_compositor;
  localparam logic [15:0] FG = 16'h0300;
  localparam logic [15:0] BG = 16'h0000;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_vsync;
  logic       i_pxon;
  logic [5:0] i_cell_x;
  logic [4:0] i_cell_y;
  logic [3:0] i_char_y;
  logic [5:0] i_cur_x;
  logic [4:0] i_cur_y;
  logic [1:0] i_cur_mode;
  logic [3:0] i_cur_h;
  logic       i_bel;
  logic [4:0] o_LCD_R;
  logic [5:0] o_LCD_G;
  logic [4:0] o_LCD_B;
  logic       o_cur_vis;
  logic       o_rev;

  int total = 0;
  int bad   = 0;

  video_compositor #(
    .COLS(64), .ROWS(32), .CHAR_H(16), .DLY(2),
    .BLINK_FRAMES(2), .BEL_FRAMES(3),
    .FG_RGB(16'h0300), .BG_RGB(16'h0000)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_vsync(i_vsync), .i_pxon(i_pxon),
    .i_cell_x(i_cell_x), .i_cell_y(i_cell_y), .i_char_y(i_char_y),
    .i_cur_x(i_cur_x), .i_cur_y(i_cur_y), .i_cur_mode(i_cur_mode),
    .i_cur_h(i_cur_h), .i_bel(i_bel),
    .o_LCD_R(o_LCD_R), .o_LCD_G(o_LCD_G), .o_LCD_B(o_LCD_B),
    .o_cur_vis(o_cur_vis), .o_rev(o_rev)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rgb();
    return {o_LCD_R, o_LCD_G, o_LCD_B};
  endfunction

  // Rising then falling vsync; the falling cycle is the frame event.
  task automatic frame(input logic bel);
    i_vsync = 1'b1;
    tick();
    i_vsync = 1'b0;
    i_bel   = bel;
    tick();
    i_bel   = 1'b0;
  endtask

  // Present a cell, then the matching glyph pixel DLY clocks later; colour
  // is sampled DLY+1 clocks after the cell.
  task automatic pixel(input string tag, input logic [5:0] x, input logic [4:0] y,
                       input logic [3:0] cy, input logic px, input logic [15:0] exp);
    i_cell_x = x; i_cell_y = y; i_char_y = cy; i_pxon = 1'b0;
    tick();
    i_cell_x = 6'd63; i_cell_y = 5'd31; i_char_y = 4'd0;
    tick();
    i_pxon = px;
    tick();
    check(tag, rgb(), exp);
    i_pxon = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_vsync = 1'b1; i_pxon = 1'b1; i_bel = 1'b0;
    i_cell_x = 6'd3; i_cell_y = 5'd5; i_char_y = 4'd15;
    i_cur_x = 6'd3; i_cur_y = 5'd5; i_cur_mode = 2'b01; i_cur_h = 4'd1;
    tick(); tick();
    check("rst_rgb", rgb(), 16'h0000);
    check("rst_vis", {15'd0, o_cur_vis}, 16'd1);
    check("rst_rev", {15'd0, o_rev}, 16'd0);
    i_rst = 1'b0;
    tick(); tick(); tick();
    check("nosync_rgb", rgb(), BG);
    check("nosync_vis", {15'd0, o_cur_vis}, 16'd1);
    check("nosync_rev", {15'd0, o_rev}, 16'd0);

    // Steady cursor at (3,5), two rows tall.
    i_pxon = 1'b0;
    frame(1'b0);
    pixel("st_cy14", 6'd3, 5'd5, 4'd14, 1'b0, FG);
    pixel("st_cy15", 6'd3, 5'd5, 4'd15, 1'b0, FG);
    pixel("st_cy13", 6'd3, 5'd5, 4'd13, 1'b0, BG);
    pixel("st_othcol", 6'd4, 5'd5, 4'd15, 1'b0, BG);
    pixel("st_glyph", 6'd3, 5'd5, 4'd13, 1'b1, FG);
    pixel("st_xor", 6'd3, 5'd5, 4'd15, 1'b1, BG);
    // Latency: colour must not appear one clock early.
    i_cell_x = 6'd3; i_cell_y = 5'd5; i_char_y = 4'd15;
    tick();
    i_cell_x = 6'd63; i_cell_y = 5'd31; i_char_y = 4'd0;
    tick();
    check("early_bg", rgb(), BG);
    tick();
    check("ontime_fg", rgb(), FG);

    // Blink mode, period 2 frames; counter 0 at start.
    i_cur_mode = 2'b10;
    frame(1'b0);
    check("bl_f1_vis", {15'd0, o_cur_vis}, 16'd1);
    pixel("bl_f1_px", 6'd3, 5'd5, 4'd15, 1'b0, FG);
    frame(1'b0);
    check("bl_f2_vis", {15'd0, o_cur_vis}, 16'd0);
    pixel("bl_f2_px", 6'd3, 5'd5, 4'd15, 1'b0, BG);
    frame(1'b0);
    check("bl_f3_vis", {15'd0, o_cur_vis}, 16'd0);
    frame(1'b0);
    check("bl_f4_vis", {15'd0, o_cur_vis}, 16'd1);
    pixel("bl_f4_px", 6'd3, 5'd5, 4'd15, 1'b0, FG);
    frame(1'b0);
    frame(1'b0);
    frame(1'b0);
    check("bl_f7_vis", {15'd0, o_cur_vis}, 16'd0);

    // Move while hidden with counter at 1: shown and counter restarted.
    i_cur_x = 6'd4;
    frame(1'b0);
    check("mv_vis", {15'd0, o_cur_vis}, 16'd1);
    pixel("mv_new", 6'd4, 5'd5, 4'd15, 1'b0, FG);
    pixel("mv_old", 6'd3, 5'd5, 4'd15, 1'b0, BG);
    frame(1'b0);
    check("mv_cnt0", {15'd0, o_cur_vis}, 16'd1);

    // Bell mid-frame with steady cursor at (4,5).
    i_cur_mode = 2'b01;
    frame(1'b0);
    tick();
    i_bel = 1'b1; tick(); i_bel = 1'b0; tick();
    check("bel_wait", {15'd0, o_rev}, 16'd0);
    frame(1'b0);
    check("bel_f1", {15'd0, o_rev}, 16'd1);
    pixel("rev_glyph", 6'd10, 5'd10, 4'd0, 1'b1, BG);
    pixel("rev_blank", 6'd10, 5'd10, 4'd0, 1'b0, FG);
    pixel("rev_cur", 6'd4, 5'd5, 4'd15, 1'b0, BG);
    frame(1'b0);
    check("bel_f2", {15'd0, o_rev}, 16'd1);
    i_bel = 1'b1; tick(); i_bel = 1'b0; tick();
    i_bel = 1'b1; tick(); i_bel = 1'b0;
    frame(1'b0);
    check("rl_f1", {15'd0, o_rev}, 16'd1);
    frame(1'b0);
    check("rl_f2", {15'd0, o_rev}, 16'd1);
    frame(1'b0);
    check("rl_f3", {15'd0, o_rev}, 16'd1);
    frame(1'b0);
    check("rl_end", {15'd0, o_rev}, 16'd0);
    frame(1'b0);
    check("rl_stay", {15'd0, o_rev}, 16'd0);

    // Bell on the frame-event cycle, then asynchronous reset mid-bell.
    frame(1'b1);
    check("bel_coinc", {15'd0, o_rev}, 16'd1);
    i_rst = 1'b1;
    #1;
    check("arst_rev", {15'd0, o_rev}, 16'd0);
    check("arst_vis", {15'd0, o_cur_vis}, 16'd1);
    check("arst_rgb", rgb(), 16'h0000);
    tick();
    i_rst = 1'b0;
    i_vsync = 1'b1;
    tick();
    check("post_rst_rev", {15'd0, o_rev}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
